stream_mux_rr: RTL and testbench

- Parametrised, registered N-channel stream multiplexer with valid/ready handshakes.
- Selection is run-time selectable: round-robin, fixed priority, or forced select.
- Merges several producer streams (DMA, CPU write path, UART/VGA fetch) onto one shared consumer port in the SoC datapath.
- Generalises the plain 4:1 32-bit combinational select to configurable width and channel count, with arbitration, back-pressure and a one-stage output register.

---
 rtl/stream_mux_rr.sv | 144 ++++++++++++++
 tb/tb_stream_mux_rr.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// Registered N-channel valid/ready stream mux with round-robin, fixed-priority or forced selection.
// Optional packet lock (in_last/out_last ports) enabled by defining STREAM_MUX_LOCK_EN.
module stream_mux_rr #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [NCH-1:0]       in_last,
`endif
  input  logic [1:0]           mode,
  input  logic [SELW-1:0]      force_sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
`ifdef STREAM_MUX_LOCK_EN
  output logic                 out_last,
`endif
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [SELW-1:0]  gsel, rr_idx;
  logic             gvalid, open, xfer;
  logic [NCH-1:0]   grant;
`ifdef STREAM_MUX_LOCK_EN
  logic             out_last_q, out_last_d;
  logic             lock_q, lock_d;
  logic [SELW-1:0]  lock_ch_q, lock_ch_d;
`endif

  always_comb begin
    gsel   = '0;
    gvalid = 1'b0;
    rr_idx = '0;
`ifdef STREAM_MUX_LOCK_EN
    if (lock_q) begin
      // a locked packet owns the port even while its producer idles
      gsel   = lock_ch_q;
      gvalid = in_valid[lock_ch_q];
    end else
`endif
    case (mode)
      2'b01: begin
        for (int i = NCH - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            gsel   = SELW'(i);
            gvalid = 1'b1;
          end
        end
      end
      2'b10: begin
        gsel   = force_sel;
        gvalid = in_valid[force_sel];
      end
      default: begin
        // index arithmetic in SELW bits wraps modulo NCH
        for (int k = 0; k < NCH; k++) begin
          rr_idx = ptr_q + SELW'(k);
          if (!gvalid && in_valid[rr_idx]) begin
            gsel   = rr_idx;
            gvalid = 1'b1;
          end
        end
      end
    endcase
  end

  assign open     = !out_valid_q || out_ready;
  assign grant    = gvalid ? ({{(NCH-1){1'b0}}, 1'b1} << gsel) : '0;
  assign in_ready = grant & {NCH{open && rst_n}};
  assign xfer     = gvalid && open && rst_n;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
`ifdef STREAM_MUX_LOCK_EN
    out_last_d  = out_last_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (open) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = in_data[gsel*WIDTH +: WIDTH];
        out_ch_d   = gsel;
`ifdef STREAM_MUX_LOCK_EN
        out_last_d = in_last[gsel];
`endif
      end
    end
    if (xfer) begin
`ifdef STREAM_MUX_LOCK_EN
      lock_d    = !in_last[gsel];
      lock_ch_d = gsel;
      if (in_last[gsel]) ptr_d = gsel + 1'b1;
`else
      ptr_d = gsel + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
`ifdef STREAM_MUX_LOCK_EN
      out_last_q  <= 1'b0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LOCK_EN
      out_last_q  <= out_last_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
`ifdef STREAM_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (NCH=4, WIDTH=32); lock scenario runs when STREAM_MUX_LOCK_EN is defined.
module tb_stream_mux_rr;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  ch_data [4];
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [3:0]   in_last;
  logic [1:0]   mode;
  logic [1:0]   force_sel;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  int           checks = 0;
  int           errors = 0;

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(32), .NCH(4), .SELW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef STREAM_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .mode      (mode),
    .force_sel (force_sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
`ifdef STREAM_MUX_LOCK_EN
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

`ifndef STREAM_MUX_LOCK_EN
  assign out_last = 1'b0;
`endif

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    mode      = 2'b00;
    force_sel = 2'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) ch_data[i] = 32'hA0 + i;
    @(negedge clk);
    checks++;
    if ({out_valid, out_ch, out_data, in_ready} !== {1'b0, 2'd0, 32'h0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state got v=%b ch=%0d d=%h rdy=%b want 0/0/0/0000",
               out_valid, out_ch, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant got rdy=%b want 0001", in_ready);
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'(k % 4), 32'hA0 + 32'(k % 4)}) begin
        errors++;
        $display("FAIL rr_beat%0d got v=%b ch=%0d d=%h want 1/%0d/%h",
                 k, out_valid, out_ch, out_data, k % 4, 32'hA0 + 32'(k % 4));
      end
    end
  endtask

  task automatic test_priority_forced();
    mode     = 2'b01;
    in_valid = 4'b1010;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL prio_ready got %b want 0010", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_ch, out_data, in_ready} !== {1'b1, 2'd1, 32'hA1, 4'b0010}) begin
        errors++;
        $display("FAIL prio_beat%0d got v=%b ch=%0d d=%h rdy=%b want 1/1/a1/0010",
                 k, out_valid, out_ch, out_data, in_ready);
      end
    end
    mode      = 2'b10;
    force_sel = 2'd3;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL forced_ready got %b want 1000", in_ready);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 32'hA3}) begin
      errors++;
      $display("FAIL forced_beat got v=%b ch=%0d d=%h want 1/3/a3", out_valid, out_ch, out_data);
    end
    force_sel = 2'd2;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL forced_invalid_ready got %b want 0000", in_ready);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== {1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL forced_invalid_out got v=%b rdy=%b want 0/0000", out_valid, in_ready);
    end
  endtask

  // ptr is 0 on entry (last transfer was ch3)
  task automatic test_back_pressure();
    mode       = 2'b00;
    in_valid   = 4'b0100;
    ch_data[2] = 32'hDEADBEEF;
    out_ready  = 1'b0;
    @(negedge clk);
    in_valid   = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({out_valid, out_ch, out_data, in_ready} !== {1'b1, 2'd2, 32'hDEADBEEF, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b ch=%0d d=%h rdy=%b want 1/2/deadbeef/0000",
                 k, out_valid, out_ch, out_data, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release_ready got %b want 0001", in_ready);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 32'hA0}) begin
      errors++;
      $display("FAIL bp_reload got v=%b ch=%0d d=%h want 1/0/a0", out_valid, out_ch, out_data);
    end
    in_valid   = 4'b0000;
    ch_data[2] = 32'hA2;
  endtask

  task automatic test_wrap();
    in_valid = 4'b0100;
    @(negedge clk);
    in_valid = 4'b1001;
    #1;
    checks++;
    if ({out_ch, in_ready} !== {2'd2, 4'b1000}) begin
      errors++;
      $display("FAIL wrap_ready got ch=%0d rdy=%b want 2/1000", out_ch, in_ready);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 32'hA3}) begin
      errors++;
      $display("FAIL wrap_ch3 got v=%b ch=%0d d=%h want 1/3/a3", out_valid, out_ch, out_data);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 32'hA0}) begin
      errors++;
      $display("FAIL wrap_ch0 got v=%b ch=%0d d=%h want 1/0/a0", out_valid, out_ch, out_data);
    end
    in_valid = 4'b0000;
  endtask

`ifdef STREAM_MUX_LOCK_EN
  // ptr is 1 on entry, so ch1 wins the first beat
  task automatic test_lock();
    in_valid = 4'b0111;
    in_last  = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_ch, out_last} !== {1'b1, 2'd1, 1'b0}) begin
        errors++;
        $display("FAIL lock_beat%0d got v=%b ch=%0d last=%b want 1/1/0", k, out_valid, out_ch, out_last);
      end
    end
    in_valid = 4'b0101;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL lock_gap_ready got %b want 0000", in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lock_gap_out got v=%b want 0", out_valid);
    end
    in_valid = 4'b0111;
    in_last  = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL lock_resume_ready got %b want 0010", in_ready);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_ch, out_last} !== {1'b1, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL lock_last got v=%b ch=%0d last=%b want 1/1/1", out_valid, out_ch, out_last);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_ch} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL lock_release got v=%b ch=%0d want 1/2", out_valid, out_ch);
    end
    in_valid = 4'b0000;
  endtask
`endif

  task automatic test_reset_mid();
    mode     = 2'b00;
    in_last  = 4'b1111;
    in_valid = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_ch, in_ready} !== {1'b0, 2'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid got v=%b ch=%0d rdy=%b want 0/0/0000", out_valid, out_ch, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 32'hA0}) begin
      errors++;
      $display("FAIL reset_mid_first got v=%b ch=%0d d=%h want 1/0/a0", out_valid, out_ch, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_priority_forced();
    test_back_pressure();
    test_wrap();
`ifdef STREAM_MUX_LOCK_EN
    test_lock();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
